split_mac_pipelined: RTL and testbench
======================================

# split_mac_pipelined

Pipelined, parametrised successor to the team's split-operand DSP multiplier. It multiplies a signed `A_W`-bit operand by a signed `B_W`-bit operand that is split into a low (unsigned, `LO_W`-bit) and high (signed) part, and recombines the two partial products. In dual mode it instead produces two independent signed lane products. Each lane feeds its own accumulator. It sits in the PIRDSP MAC models as the cycle-accurate reference for a 3-stage DSP MAC with fracturable multiplier and accumulation.

## Interface
- `A_W`, 27, width of operand `a`
- `B_W`, 18, width of operand `b`; `HI_W = B_W - LO_W`
- `LO_W`, 9, width of the low split of `b`; `1 <= LO_W < B_W`
- `ACC_W`, 48, accumulator and result width; must be `>= A_W + B_W`

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `in_valid`  in  1  sample accepted this cycle
- `in_mode`  in  1  0 = full `a*b`, 1 = dual lanes
- `acc_en`  in  1  1 = add product to accumulator, 0 = load product
- `acc_clr`  in  1  force load and clear sticky overflow flags (qualified by `in_valid`)
- `a`  in  `A_W`  signed operand
- `b`  in  `B_W`  signed operand; dual mode: `b[LO_W-1:0]` = lane-0 signed, `b[B_W-1:LO_W]` = lane-1 signed
- `out_valid`  out  1  results updated this cycle
- `result_lo`  out  `ACC_W`  lane-0 accumulator (full product in mode 0)
- `result_hi`  out  `ACC_W`  lane-1 accumulator (0 in mode 0)
- `ovf_lo`, `ovf_hi`  out  1 each  sticky signed-overflow flags per lane

## Operation
- S1: register `a`, `b`, `in_mode`, `acc_en`, `acc_clr`, `in_valid`.
- S2: `p_lo = a * b_lo_ext`, where `b_lo_ext` = zero-extended `b[LO_W-1:0]` (mode 0) or sign-extended (mode 1); width `A_W+LO_W+1`. `p_hi = a * signed(b[B_W-1:LO_W])`, width `A_W+HI_W`. Both registered with control.
- S3, mode 0: `prod = sext(p_lo) + (sext(p_hi) << LO_W)`, bit-exact `a*b`; `acc_lo <= load ? prod : acc_lo + prod`; `acc_hi <= 0`; `ovf_hi` unchanged.
- S3, mode 1: `acc_lo` uses `sext(p_lo)` and `acc_hi` uses `sext(p_hi)` (no shift), each load-or-add independently.
- `load = !acc_en | acc_clr | (mode != mode of previous S3 sample)`. The first sample after reset counts as a mode change.
- Accumulation wraps in two's complement at `ACC_W`. The lane's `ovf` is set when both addends have equal sign and the sum sign differs. It is sticky until `acc_clr` or reset.
- `acc_clr` on a sample clears `ovf_*` before that sample's own overflow is evaluated. Load never sets overflow.
- Bubbles (`in_valid=0`) propagate. Accumulators, flags and mode history hold when S3 is invalid.

## Timing
- Latency 3: sample accepted at edge k → `out_valid=1` and results updated at edge k+3.
- Throughput 1 sample/cycle. No backpressure; `out_valid` is a 1-cycle pulse per sample.
- Outputs hold their values between `out_valid` pulses.
- Reset (`rst_n=0` at an edge): all stage valids, accumulators, `result_*`, `ovf_*` = 0; mode history invalid. In-flight samples are discarded. Samples presented while in reset are ignored.
- Reset mid-stream: first `out_valid` after release comes only from a sample accepted after release, 3 cycles later.
- Back-to-back samples with a mode change: the change takes effect exactly on the sample that carries it. No stall.

## Test plan
- Full mode, `acc_en=0`: `a=-1, b=-131072` → `result_lo=131072`, `result_hi=0`, `out_valid` 3 cycles after `in_valid`. Then `a=-67108864, b=-131072` → `result_lo=8796093022208`.
- Dual mode, `acc_en=0`: `a=100`, `b=-1531` (hi=-3, lo=5) → `result_lo=500`, `result_hi=-300`. Same `b` in mode 0 → `result_lo=-153100`.
- Accumulate: 4 back-to-back mode-0 samples `a=1000, b=3`, first with `acc_clr=1`, rest `acc_en=1` → `result_lo` 3000, 6000, 9000, 12000 on consecutive cycles. Insert one bubble → one-cycle gap, same values.
- Overflow with `ACC_W=45`: two samples `a=-2^26, b=-2^17` (load, then add) → `result_lo=-2^44`, `ovf_lo=1`, `ovf_hi=0`. The flag stays set until a sample with `acc_clr=1`, which loads and clears it.
- Mode switch: accumulate mode-0 to 12000, then a mode-1 sample `a=2, b=(1<<9)|1` with `acc_en=1` → forced load: `result_lo=2`, `result_hi=2`.
- Reset mid-pipeline: 3 samples in flight, `rst_n=0` for 1 cycle → no `out_valid` for the discarded samples, all outputs 0. The next sample after release loads regardless of `acc_en`.

Source files
------------

// File: rtl/split_mac_pipelined_if.sv
// Sample/result bundle of the split-operand MAC: the producer drives operands
// and control, the MAC drives lane accumulators and sticky overflow flags.
interface split_mac_pipelined_if #(
  parameter int A_W   = 27,
  parameter int B_W   = 18,
  parameter int ACC_W = 48
);
  logic             in_valid;
  logic             in_mode;
  logic             acc_en;
  logic             acc_clr;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             out_valid;
  logic [ACC_W-1:0] result_lo;
  logic [ACC_W-1:0] result_hi;
  logic             ovf_lo;
  logic             ovf_hi;

  modport master (
    output in_valid, in_mode, acc_en, acc_clr, a, b,
    input  out_valid, result_lo, result_hi, ovf_lo, ovf_hi
  );

  modport slave (
    input  in_valid, in_mode, acc_en, acc_clr, a, b,
    output out_valid, result_lo, result_hi, ovf_lo, ovf_hi
  );
endinterface

// File: rtl/split_mac_pipelined.sv
// Split-operand signed multiplier with per-lane accumulators: b is cut into a low
// and high part, both partial products are formed, then recombined or kept as lanes.
module split_mac_pipelined #(
  parameter int A_W   = 27,
  parameter int B_W   = 18,
  parameter int LO_W  = 9,
  parameter int ACC_W = 48
) (
  input logic                  clk,
  input logic                  rst_n,
  split_mac_pipelined_if.slave bus
);
  localparam int HI_W  = B_W - LO_W;
  localparam int PLO_W = A_W + LO_W + 1;
  localparam int PHI_W = A_W + HI_W;

  function automatic logic add_ovf(input logic [ACC_W-1:0] x,
                                   input logic [ACC_W-1:0] y,
                                   input logic [ACC_W-1:0] s);
    return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
  endfunction

  logic                    s1_valid_r, s1_mode_r, s1_en_r, s1_clr_r;
  logic signed [A_W-1:0]   s1_a_r;
  logic [B_W-1:0]          s1_b_r;

  logic signed [PLO_W-1:0] a_lo_x_s, b_lo_x_s, p_lo_s;
  logic signed [PHI_W-1:0] a_hi_x_s, b_hi_x_s, p_hi_s;

  logic                    s2_valid_r, s2_mode_r, s2_en_r, s2_clr_r;
  logic signed [PLO_W-1:0] p_lo_r;
  logic signed [PHI_W-1:0] p_hi_r;

  logic signed [ACC_W-1:0] p_lo_x_s, p_hi_x_s, add_lo_s, add_hi_s;

  logic                    s3_valid_r, s3_mode_r, s3_en_r, s3_clr_r;
  logic signed [ACC_W-1:0] add_lo_r, add_hi_r;

  logic                    load_s, ovf_lo_base_s, ovf_hi_base_s;
  logic signed [ACC_W-1:0] sum_lo_s, sum_hi_s, acc_lo_n_s, acc_hi_n_s;
  logic                    ovf_lo_n_s, ovf_hi_n_s;

  logic signed [ACC_W-1:0] acc_lo_r, acc_hi_r;
  logic                    ovf_lo_r, ovf_hi_r, out_valid_r;
  logic                    hist_valid_r, hist_mode_r;

  // Stage 1: capture the incoming sample and its control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_mode_r  <= 1'b0;
      s1_en_r    <= 1'b0;
      s1_clr_r   <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
    end else begin
      s1_valid_r <= bus.in_valid;
      s1_mode_r  <= bus.in_mode;
      s1_en_r    <= bus.acc_en;
      s1_clr_r   <= bus.acc_clr;
      s1_a_r     <= bus.a;
      s1_b_r     <= bus.b;
    end
  end

  // Partial products; the low slice of b is unsigned in full mode, signed in dual mode.
  always_comb begin
    a_lo_x_s = PLO_W'(s1_a_r);
    if (s1_mode_r) begin
      b_lo_x_s = PLO_W'($signed(s1_b_r[LO_W-1:0]));
    end else begin
      b_lo_x_s = PLO_W'($unsigned(s1_b_r[LO_W-1:0]));
    end
    p_lo_s   = a_lo_x_s * b_lo_x_s;
    a_hi_x_s = PHI_W'(s1_a_r);
    b_hi_x_s = PHI_W'($signed(s1_b_r[B_W-1:LO_W]));
    p_hi_s   = a_hi_x_s * b_hi_x_s;
  end

  // Stage 2: register partial products alongside the control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_mode_r  <= 1'b0;
      s2_en_r    <= 1'b0;
      s2_clr_r   <= 1'b0;
      p_lo_r     <= '0;
      p_hi_r     <= '0;
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_mode_r  <= s1_mode_r;
      s2_en_r    <= s1_en_r;
      s2_clr_r   <= s1_clr_r;
      p_lo_r     <= p_lo_s;
      p_hi_r     <= p_hi_s;
    end
  end

  // Recombine into the full product, or keep the two lane products apart.
  always_comb begin
    p_lo_x_s = ACC_W'(p_lo_r);
    p_hi_x_s = ACC_W'(p_hi_r);
    if (s2_mode_r) begin
      add_lo_s = p_lo_x_s;
      add_hi_s = p_hi_x_s;
    end else begin
      add_lo_s = p_lo_x_s + (p_hi_x_s <<< LO_W);
      add_hi_s = '0;
    end
  end

  // Stage 3: register lane addends ahead of the accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_valid_r <= 1'b0;
      s3_mode_r  <= 1'b0;
      s3_en_r    <= 1'b0;
      s3_clr_r   <= 1'b0;
      add_lo_r   <= '0;
      add_hi_r   <= '0;
    end else begin
      s3_valid_r <= s2_valid_r;
      s3_mode_r  <= s2_mode_r;
      s3_en_r    <= s2_en_r;
      s3_clr_r   <= s2_clr_r;
      add_lo_r   <= add_lo_s;
      add_hi_r   <= add_hi_s;
    end
  end

  // Load-or-add per lane; a mode change (or no history after reset) forces a load.
  always_comb begin
    load_s        = !s3_en_r || s3_clr_r || !hist_valid_r || (s3_mode_r != hist_mode_r);
    sum_lo_s      = acc_lo_r + add_lo_r;
    sum_hi_s      = acc_hi_r + add_hi_r;
    ovf_lo_base_s = s3_clr_r ? 1'b0 : ovf_lo_r;
    ovf_hi_base_s = s3_clr_r ? 1'b0 : ovf_hi_r;
    acc_lo_n_s    = acc_lo_r;
    acc_hi_n_s    = acc_hi_r;
    ovf_lo_n_s    = ovf_lo_r;
    ovf_hi_n_s    = ovf_hi_r;
    if (s3_valid_r) begin
      if (load_s) begin
        acc_lo_n_s = add_lo_r;
        ovf_lo_n_s = ovf_lo_base_s;
      end else begin
        acc_lo_n_s = sum_lo_s;
        ovf_lo_n_s = ovf_lo_base_s | add_ovf(acc_lo_r, add_lo_r, sum_lo_s);
      end
      if (!s3_mode_r) begin
        acc_hi_n_s = '0;
        ovf_hi_n_s = ovf_hi_base_s;
      end else if (load_s) begin
        acc_hi_n_s = add_hi_r;
        ovf_hi_n_s = ovf_hi_base_s;
      end else begin
        acc_hi_n_s = sum_hi_s;
        ovf_hi_n_s = ovf_hi_base_s | add_ovf(acc_hi_r, add_hi_r, sum_hi_s);
      end
    end else begin
      acc_lo_n_s = acc_lo_r;
      acc_hi_n_s = acc_hi_r;
    end
  end

  // Accumulators, sticky flags and mode history; these are the block outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_lo_r     <= '0;
      acc_hi_r     <= '0;
      ovf_lo_r     <= 1'b0;
      ovf_hi_r     <= 1'b0;
      out_valid_r  <= 1'b0;
      hist_valid_r <= 1'b0;
      hist_mode_r  <= 1'b0;
    end else begin
      acc_lo_r    <= acc_lo_n_s;
      acc_hi_r    <= acc_hi_n_s;
      ovf_lo_r    <= ovf_lo_n_s;
      ovf_hi_r    <= ovf_hi_n_s;
      out_valid_r <= s3_valid_r;
      if (s3_valid_r) begin
        hist_valid_r <= 1'b1;
        hist_mode_r  <= s3_mode_r;
      end else begin
        hist_valid_r <= hist_valid_r;
        hist_mode_r  <= hist_mode_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.result_lo = acc_lo_r;
  assign bus.result_hi = acc_hi_r;
  assign bus.ovf_lo    = ovf_lo_r;
  assign bus.ovf_hi    = ovf_hi_r;
endmodule

// File: tb/tb_split_mac_pipelined.sv
// Directed + random bench: a wide-integer reference model fills a scoreboard at
// drive time; a monitor pops and compares on every out_valid pulse.
module tb_split_mac_pipelined;
  localparam int A_W = 27, B_W = 18, LO_W = 9, ACC_W = 48, ACC2_W = 45;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [ACC_W-1:0] lo;
    logic [ACC_W-1:0] hi;
    logic             ol;
    logic             oh;
    int               due;
  } exp_t;
  exp_t sb[$];

  longint m_lo, m_hi;
  bit     m_ol, m_oh, m_hv, m_hm;

  split_mac_pipelined_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W))  bus1 ();
  split_mac_pipelined_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC2_W)) bus2 ();

  split_mac_pipelined #(.A_W(A_W), .B_W(B_W), .LO_W(LO_W), .ACC_W(ACC_W))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus1));
  split_mac_pipelined #(.A_W(A_W), .B_W(B_W), .LO_W(LO_W), .ACC_W(ACC2_W))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic longint wrap(input longint x);
    logic signed [ACC_W-1:0] t;
    t = x[ACC_W-1:0];
    return longint'(t);
  endfunction

  function automatic bit ovf_of(input longint acc, input longint p);
    return wrap(acc + p) != (acc + p);
  endfunction

  task automatic model_reset();
    m_lo = 0; m_hi = 0; m_ol = 1'b0; m_oh = 1'b0; m_hv = 1'b0; m_hm = 1'b0;
  endtask

  task automatic send(input bit mode, input bit en, input bit clr, input longint av, input longint bv);
    logic [B_W-1:0] bb;
    longint p_lo, p_hi;
    bit load;
    exp_t e;
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_mode  = mode;
    bus1.acc_en   = en;
    bus1.acc_clr  = clr;
    bus1.a        = av[A_W-1:0];
    bus1.b        = bv[B_W-1:0];
    bb = bv[B_W-1:0];
    if (mode) begin
      p_lo = av * longint'($signed(bb[LO_W-1:0]));
      p_hi = av * longint'($signed(bb[B_W-1:LO_W]));
    end else begin
      p_lo = av * longint'($signed(bb));
      p_hi = 0;
    end
    load = !en || clr || !m_hv || (mode != m_hm);
    if (clr) begin m_ol = 1'b0; m_oh = 1'b0; end
    if (load) m_lo = wrap(p_lo);
    else begin m_ol = m_ol | ovf_of(m_lo, p_lo); m_lo = wrap(m_lo + p_lo); end
    if (!mode) m_hi = 0;
    else if (load) m_hi = wrap(p_hi);
    else begin m_oh = m_oh | ovf_of(m_hi, p_hi); m_hi = wrap(m_hi + p_hi); end
    m_hv = 1'b1;
    m_hm = mode;
    e.lo = m_lo[ACC_W-1:0];
    e.hi = m_hi[ACC_W-1:0];
    e.ol = m_ol;
    e.oh = m_oh;
    e.due = cyc + 4;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus1.in_valid = 1'b0;
    end
  endtask

  task automatic send2(input bit en, input bit clr, input longint av, input longint bv);
    bit seen;
    @(negedge clk);
    bus2.in_valid = 1'b1;
    bus2.in_mode  = 1'b0;
    bus2.acc_en   = en;
    bus2.acc_clr  = clr;
    bus2.a        = av[A_W-1:0];
    bus2.b        = bv[B_W-1:0];
    @(negedge clk);
    bus2.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus2.out_valid === 1'b1) seen = 1'b1;
    end
    chk("acc45_out_valid", 64'(seen), 64'd1);
  endtask

  // Scoreboard monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus1.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 64'(bus1.out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result_lo", 64'(bus1.result_lo), 64'(e.lo));
        chk("result_hi", 64'(bus1.result_hi), 64'(e.hi));
        chk("ovf_lo", 64'(bus1.ovf_lo), 64'(e.ol));
        chk("ovf_hi", 64'(bus1.ovf_hi), 64'(e.oh));
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    logic [A_W-1:0] ra;
    logic [B_W-1:0] rb;
    bus1.in_valid = 1'b0; bus1.in_mode = 1'b0; bus1.acc_en = 1'b0; bus1.acc_clr = 1'b0;
    bus1.a = '0; bus1.b = '0;
    bus2.in_valid = 1'b0; bus2.in_mode = 1'b0; bus2.acc_en = 1'b0; bus2.acc_clr = 1'b0;
    bus2.a = '0; bus2.b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_result_lo", 64'(bus1.result_lo), 64'd0);
    chk("rst_result_hi", 64'(bus1.result_hi), 64'd0);
    chk("rst_out_valid", 64'(bus1.out_valid), 64'd0);
    chk("rst_ovf", {62'd0, bus1.ovf_hi, bus1.ovf_lo}, 64'd0);
    rst_n = 1'b1;

    // Full-mode loads, including the most negative b.
    send(1'b0, 1'b0, 1'b0, -1, -131072);
    send(1'b0, 1'b0, 1'b0, -67108864, -131072);
    // Dual lanes, then the same b as a full operand.
    send(1'b1, 1'b0, 1'b0, 100, -1531);
    send(1'b0, 1'b0, 1'b0, 100, -1531);
    // Back-to-back accumulation, then the same with a bubble.
    send(1'b0, 1'b1, 1'b1, 1000, 3);
    repeat (3) send(1'b0, 1'b1, 1'b0, 1000, 3);
    idle(2);
    send(1'b0, 1'b1, 1'b1, 1000, 3);
    send(1'b0, 1'b1, 1'b0, 1000, 3);
    idle(1);
    send(1'b0, 1'b1, 1'b0, 1000, 3);
    send(1'b0, 1'b1, 1'b0, 1000, 3);
    // Mode switch forces a load despite acc_en.
    send(1'b1, 1'b1, 1'b0, 2, (1 << 9) | 1);
    idle(4);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        ra = A_W'($urandom);
        rb = B_W'($urandom);
        send(1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0), ($urandom_range(0, 7) == 0),
             longint'($signed(ra)), longint'($signed(rb)));
      end
    end
    idle(6);

    // Reset with three samples in flight and one presented during reset.
    send(1'b0, 1'b1, 1'b1, 1000, 3);
    send(1'b0, 1'b1, 1'b0, 7, 7);
    send(1'b1, 1'b1, 1'b0, 3, 5);
    @(negedge clk);
    rst_n = 1'b0;
    bus1.in_valid = 1'b1;
    sb.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus1.in_valid = 1'b0;
    chk("midrst_result_lo", 64'(bus1.result_lo), 64'd0);
    chk("midrst_result_hi", 64'(bus1.result_hi), 64'd0);
    chk("midrst_out_valid", 64'(bus1.out_valid), 64'd0);
    chk("midrst_ovf", {62'd0, bus1.ovf_hi, bus1.ovf_lo}, 64'd0);
    idle(4);
    send(1'b0, 1'b1, 1'b0, 11, 13);
    idle(5);

    // Overflow on the 45-bit accumulator: 2^43 + 2^43 wraps to -2^44.
    send2(1'b0, 1'b0, -67108864, -131072);
    chk("acc45_load", 64'(bus2.result_lo), 64'h0000_0800_0000_0000);
    chk("acc45_load_ovf", 64'(bus2.ovf_lo), 64'd0);
    send2(1'b1, 1'b0, -67108864, -131072);
    chk("acc45_wrap", 64'(bus2.result_lo), 64'h0000_1000_0000_0000);
    chk("acc45_ovf_lo", 64'(bus2.ovf_lo), 64'd1);
    chk("acc45_ovf_hi", 64'(bus2.ovf_hi), 64'd0);
    send2(1'b1, 1'b0, 1, 1);
    chk("acc45_sticky_val", 64'(bus2.result_lo), 64'h0000_1000_0000_0001);
    chk("acc45_sticky_ovf", 64'(bus2.ovf_lo), 64'd1);
    send2(1'b1, 1'b1, 5, 7);
    chk("acc45_clr_val", 64'(bus2.result_lo), 64'd35);
    chk("acc45_clr_ovf", 64'(bus2.ovf_lo), 64'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
